// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Turns single-cycle request pulses into clean high levels of programmable
// length. Each high is followed by a programmable minimum low gap. Requests
// that arrive while an output is in progress are counted in a saturating
// pending counter and replayed in order.
//
// Optional feature macro: PULSE_STRETCH_QUEUE_EN
//   defined     -> pending-request counter present; busy-time requests queue.
//   not defined -> no queue; busy-time requests are dropped and flag overflow.
//
// Parameters
//   CNT_W   width of the length/gap counters and of len/gap
//   PEND_W  width of the pending-request counter
//
// Ports
//   clk        clock, all logic on rising edge
//   rst_n      asynchronous active-low reset
//   pulse_in   request, every sampled high cycle is one request
//   len        high time in cycles (0 behaves as 1)
//   gap        minimum low time after each high (0 behaves as 1)
//   clr_ovf    synchronous clear of overflow (a coincident set wins)
//   level_out  stretched output level (registered)
//   busy       high while in HIGH or GAP (registered)
//   pending    queued requests not yet started
//   overflow   sticky flag: a request was lost
// -----------------------------------------------------------------------------
module pulse_stretcher #(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  len,
    input  logic [CNT_W-1:0]  gap,
    input  logic              clr_ovf,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_gap_lat;
    logic              r_level;
    logic              r_busy;
    logic [PEND_W-1:0] r_pend;
    logic              r_ovf;

    // Counters are loaded with (length - 1) and run down to zero, so a
    // programmed 0 and a programmed 1 both give a single-cycle phase.
    logic [CNT_W-1:0]  w_len_m1;
    logic [CNT_W-1:0]  w_gap_m1;
    logic              w_cnt_zero;
    logic              w_gap_end;
    logic              w_req_busy;
    logic              w_drop;
    logic              w_restart;
    logic [PEND_W-1:0] w_pend_next;

    assign w_len_m1   = (len == '0) ? '0 : len - CNT_W'(1);
    assign w_gap_m1   = (gap == '0) ? '0 : gap - CNT_W'(1);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_gap_end  = (r_state == S_GAP) && w_cnt_zero;
    assign w_req_busy = pulse_in && (r_state != S_IDLE);

`ifdef PULSE_STRETCH_QUEUE_EN
    logic w_pend_full;
    logic w_accept;

    assign w_pend_full = (r_pend == {PEND_W{1'b1}});
    // On the final GAP cycle a full counter is also being decremented, so
    // the incoming request still fits and nothing is lost.
    assign w_accept    = w_req_busy && (!w_pend_full || w_gap_end);
    assign w_drop      = w_req_busy && !w_accept;
    // A request arriving on the final GAP cycle is consumed immediately,
    // even when the counter was empty.
    assign w_restart   = w_gap_end && ((r_pend != '0) || w_req_busy);

    always_comb begin
        w_pend_next = r_pend;
        if (w_accept && !w_restart) begin
            w_pend_next = r_pend + PEND_W'(1);
        end else if (!w_accept && w_restart) begin
            w_pend_next = r_pend - PEND_W'(1);
        end
    end
`else
    assign w_drop      = w_req_busy;
    assign w_restart   = 1'b0;
    assign w_pend_next = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_gap_lat <= '0;
            r_level   <= 1'b0;
            r_busy    <= 1'b0;
            r_pend    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pend <= w_pend_next;

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (pulse_in) begin
                        r_state   <= S_HIGH;
                        r_cnt     <= w_len_m1;
                        r_gap_lat <= w_gap_m1;
                        r_level   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_cnt_zero) begin
                        r_state <= S_GAP;
                        r_cnt   <= r_gap_lat;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_cnt_zero) begin
                        if (w_restart) begin
                            r_state   <= S_HIGH;
                            r_cnt     <= w_len_m1;
                            r_gap_lat <= w_gap_m1;
                            r_level   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_level <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign level_out = r_level;
    assign busy      = r_busy;
    assign pending   = r_pend;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Directed bench for pulse_stretcher (CNT_W=8, PEND_W=2). Inputs change 1 ns
// after a rising edge, outputs are sampled at that point, so each sample shows
// the register values produced by the edge just taken. Exercises the queued
// build when PULSE_STRETCH_QUEUE_EN is defined, the queue-less build otherwise.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_stretcher;

    localparam int CNT_W  = 8;
    localparam int PEND_W = 2;

    logic              clk;
    logic              rst_n;
    logic              pulse_in;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  gap;
    logic              clr_ovf;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    int n_cmp;
    int n_bad;

    pulse_stretcher #(
        .CNT_W  (CNT_W),
        .PEND_W (PEND_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .len       (len),
        .gap       (gap),
        .clr_ovf   (clr_ovf),
        .level_out (level_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Drive one cycle of inputs, take the edge, then return 1 ns after it.
    task automatic tick(input logic p, input logic c);
        pulse_in = p;
        clr_ovf  = c;
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    // Bit i of each vector is the stimulus / expected value after tick i.
    task automatic run_seq(input string name, input int n,
                           input logic [31:0] pul, input logic [31:0] clr,
                           input logic [31:0] lvl, input logic [31:0] bsy,
                           input logic [31:0] pnd);
        for (int i = 0; i < n; i++) begin
            tick(pul[i], clr[i]);
            check($sformatf("%s_lvl%0d", name, i), {31'b0, level_out}, {31'b0, lvl[i]});
            check($sformatf("%s_bsy%0d", name, i), {31'b0, busy}, {31'b0, bsy[i]});
            check($sformatf("%s_pnd%0d", name, i), 32'(pending), {31'b0, pnd[i]});
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_lvl"}, {31'b0, level_out}, 32'd0);
        check({name, "_bsy"}, {31'b0, busy}, 32'd0);
        check({name, "_pnd"}, 32'(pending), 32'd0);
        check({name, "_ovf"}, {31'b0, overflow}, 32'd0);
    endtask

    initial begin
        int rises;
        int guard;
        logic prev;

        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b1;
        pulse_in = 1'b0;
        clr_ovf  = 1'b0;
        len      = 8'd3;
        gap      = 8'd2;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        check_idle("post_reset");

        // Single request, len=3 gap=2: high for 3 samples, busy for 5.
        len = 8'd3; gap = 8'd2;
        run_seq("single", 7, 32'h1, 32'h0, 32'h07, 32'h1F, 32'h0);

        // Zero settings behave as 1.
        len = 8'd0; gap = 8'd0;
        run_seq("zero", 4, 32'h1, 32'h0, 32'h1, 32'h3, 32'h0);

`ifdef PULSE_STRETCH_QUEUE_EN
        // Pulses at ticks 0, 2 and 6 (last GAP cycle): three back-to-back highs.
        len = 8'd4; gap = 8'd2;
        run_seq("queue", 20, 32'h45, 32'h0, 32'hF3CF, 32'h3FFFF, 32'h0FFC);
        check("queue_ovf", {31'b0, overflow}, 32'd0);

        // Saturation: first pulse plus five during HIGH; last drop collides with clear.
        len = 8'd8; gap = 8'd2;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("sat_pnd3", 32'(pending), 32'd3);
        check("sat_ovf_before", {31'b0, overflow}, 32'd0);
        tick(1'b1, 1'b0);
        check("sat_pnd_hold", 32'(pending), 32'd3);
        check("sat_ovf_set", {31'b0, overflow}, 32'd1);
        tick(1'b1, 1'b1);
        check("clr_collide_ovf", {31'b0, overflow}, 32'd1);
        check("sat_pnd_hold2", 32'(pending), 32'd3);

        rises = 1;
        prev  = level_out;
        guard = 0;
        while (busy && guard < 200) begin
            tick(1'b0, 1'b0);
            if (level_out && !prev) rises++;
            prev = level_out;
            guard++;
        end
        check("sat_drain_busy", {31'b0, busy}, 32'd0);
        check("sat_highs", 32'(rises), 32'd4);
        check("sat_pnd_end", 32'(pending), 32'd0);
        tick(1'b0, 1'b1);
        check("clr_alone_ovf", {31'b0, overflow}, 32'd0);

        // Reset mid-HIGH with a full queue and overflow set.
        len = 8'd8; gap = 8'd2;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        check("pre_rst_lvl", {31'b0, level_out}, 32'd1);
        check("pre_rst_pnd", 32'(pending), 32'd3);
        check("pre_rst_ovf", {31'b0, overflow}, 32'd1);
`else
        // Queue-less: pulses at ticks 2 and 6 are dropped, only one high appears.
        // The drop at tick 6 coincides with a clear, so overflow stays set.
        len = 8'd4; gap = 8'd2;
        run_seq("noq", 8, 32'h45, 32'h40, 32'h0F, 32'h3F, 32'h0);
        check("clr_collide_ovf", {31'b0, overflow}, 32'd1);
        tick(1'b0, 1'b1);
        check("clr_alone_ovf", {31'b0, overflow}, 32'd0);

        // Reset mid-HIGH after a dropped request.
        len = 8'd8; gap = 8'd2;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("pre_rst_lvl", {31'b0, level_out}, 32'd1);
        check("pre_rst_ovf", {31'b0, overflow}, 32'd1);
`endif
        // Assert reset between edges; outputs must clear without a clock.
        #1 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        check_idle("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
